// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_padder
// Description : Byte-stream to 512-bit block assembler for the SHA-256 core.
//               Appends the 0x80 marker, zero fill and the 64-bit big-endian
//               message bit length, and tags each block with first/last flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_first,
    output logic         block_last,
    input  logic         block_ack
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PAD    = 2'd1,
        LENBLK = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [511:0]   blk_buf;
    logic [511:0]   buf_nxt;
    logic [5:0]     byte_cnt;
    logic [LEN_W-1:0] bit_len;
    logic           first_pend;
    logic           pad_pend;
    logic           len_only;
    logic           final_blk;

    logic           accept;
    logic           has_byte;
    logic           ack_take;
    logic           cnt_full;
    logic           len_fits;
    logic [63:0]    len64;

    assign in_ready    = (state == FILL) & ~rst;
    assign accept      = in_valid & in_ready;
    // An in_last beat flagged empty terminates the message without a byte.
    assign has_byte    = ~(in_last & in_empty);
    assign block_valid = (state == EMIT) & ~rst;
    assign ack_take    = block_valid & block_ack;
    assign cnt_full    = (byte_cnt == 6'd63);
    // Bytes 56..63 must be free for the length field to share the pad block.
    assign len_fits    = (byte_cnt <= 6'd55);
    assign len64       = 64'(bit_len);

    assign block_out   = blk_buf;
    assign block_first = block_valid & first_pend;
    assign block_last  = block_valid & final_blk;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (has_byte) begin
                        if (cnt_full) begin
                            state_nxt = EMIT;
                        end else if (in_last) begin
                            state_nxt = PAD;
                        end
                    end else begin
                        state_nxt = PAD;
                    end
                end
            end
            PAD:    state_nxt = EMIT;
            LENBLK: state_nxt = EMIT;
            EMIT: begin
                if (ack_take) begin
                    if (final_blk) begin
                        state_nxt = FILL;
                    end else if (len_only) begin
                        state_nxt = LENBLK;
                    end else if (pad_pend) begin
                        state_nxt = PAD;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Block buffer update: byte insert, padding, or length-only block.
    always_comb begin
        buf_nxt = blk_buf;
        case (state)
            FILL: begin
                if (accept && has_byte) begin
                    for (int i = 0; i < 64; i++) begin
                        if (byte_cnt == 6'(i)) begin
                            buf_nxt[511-8*i -: 8] = in_data;
                        end
                    end
                end
            end
            PAD: begin
                for (int i = 0; i < 64; i++) begin
                    if (byte_cnt == 6'(i)) begin
                        buf_nxt[511-8*i -: 8] = 8'h80;
                    end else if (6'(i) > byte_cnt) begin
                        buf_nxt[511-8*i -: 8] = 8'h00;
                    end
                end
                if (len_fits) begin
                    buf_nxt[63:0] = len64;
                end
            end
            LENBLK: buf_nxt = {448'd0, len64};
            default: buf_nxt = blk_buf;
        endcase
    end

    // Datapath registers: buffer, byte position, bit length and block flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_buf    <= '0;
            byte_cnt   <= '0;
            bit_len    <= '0;
            first_pend <= 1'b1;
            pad_pend   <= 1'b0;
            len_only   <= 1'b0;
            final_blk  <= 1'b0;
        end else begin
            blk_buf <= buf_nxt;
            case (state)
                FILL: begin
                    if (accept && has_byte) begin
                        bit_len <= bit_len + LEN_W'(8);
                        if (cnt_full) begin
                            // Full block: padding (if any) follows in a fresh block.
                            pad_pend <= in_last;
                        end else begin
                            byte_cnt <= byte_cnt + 6'd1;
                        end
                    end
                end
                PAD: begin
                    final_blk <= len_fits;
                    len_only  <= ~len_fits;
                end
                LENBLK: begin
                    final_blk <= 1'b1;
                end
                EMIT: begin
                    if (ack_take) begin
                        byte_cnt   <= '0;
                        first_pend <= 1'b0;
                        if (final_blk) begin
                            bit_len    <= '0;
                            first_pend <= 1'b1;
                            pad_pend   <= 1'b0;
                            len_only   <= 1'b0;
                            final_blk  <= 1'b0;
                        end else if (len_only) begin
                            len_only <= 1'b0;
                        end else if (pad_pend) begin
                            pad_pend <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_padder
// Description : Directed scoreboard bench for sha256_msg_padder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_empty;
    logic         in_ready;
    logic [511:0] block_out;
    logic         block_valid;
    logic         block_first;
    logic         block_last;
    logic         block_ack;

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] msg[$];
    int         total = 0;
    int         bad   = 0;

    sha256_msg_padder dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .in_ready    (in_ready),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_first (block_first),
        .block_last  (block_last),
        .block_ack   (block_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit length, to a multiple of 64 bytes.
    task automatic push_expected();
        logic [7:0]  p[$];
        logic [63:0] len;
        exp_t        e;
        int          n;
        int          tot;
        int          nb;
        n   = msg.size();
        tot = ((n + 9 + 63) / 64) * 64;
        nb  = tot / 64;
        len = 64'(n) * 64'd8;
        p   = msg;
        p.push_back(8'h80);
        while (p.size() < tot - 8) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[b*64 + i];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        int guard;
        guard    = 0;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("send_timeout", 512'(guard >= 200), 512'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg();
        if (msg.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++) send_beat(msg[i], i == msg.size() - 1, 1'b0);
        end
    endtask

    // Wait for a block, compare against the scoreboard, hold off ack, then ack.
    task automatic wait_block(input int hold);
        exp_t e;
        int   guard;
        guard = 0;
        while (block_valid !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("blk_timeout", 512'(block_valid), 512'd1);
        chk("sb_nonempty", 512'(sb.size() > 0), 512'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("block_out", block_out, e.blk);
        chk("block_first", 512'(block_first), 512'(e.first));
        chk("block_last", 512'(block_last), 512'(e.last));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out", block_out, e.blk);
            chk("hold_first", 512'(block_first), 512'(e.first));
            chk("hold_last", 512'(block_last), 512'(e.last));
            chk("hold_valid", 512'(block_valid), 512'd1);
            chk("hold_ready", 512'(in_ready), 512'd0);
        end
        block_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        block_ack = 1'b0;
        chk("valid_drop", 512'(block_valid), 512'd0);
        // Only a final block returns to byte intake right away for messages up to 64 bytes.
        chk("ready_after_ack", 512'(in_ready), 512'(e.last));
    endtask

    task automatic run_msg(input int hold);
        int nb;
        push_expected();
        nb = sb.size();
        send_msg();
        for (int b = 0; b < nb; b++) wait_block(hold);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_empty  = 1'b0;
        block_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 512'(in_ready), 512'd0);
        chk("rst_valid", 512'(block_valid), 512'd0);
        chk("rst_first", 512'(block_first), 512'd0);
        chk("rst_last", 512'(block_last), 512'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 512'(in_ready), 512'd1);

        // "abc" with latency check and immediate ack.
        msg = '{8'h61, 8'h62, 8'h63};
        push_expected();
        send_msg();
        chk("lat_n1", 512'(block_valid), 512'd0);
        @(negedge clk);
        chk("lat_n2", 512'(block_valid), 512'd1);
        wait_block(0);

        // Empty message.
        msg = {};
        run_msg(0);

        // 55 bytes: length still fits in the pad block.
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'(i + 1));
        run_msg(0);

        // 56 zero bytes: pad block plus length-only block.
        msg = {};
        for (int i = 0; i < 56; i++) msg.push_back(8'h00);
        run_msg(0);

        // 64 bytes 0x00..0x3F: raw data block then pad block.
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'(i));
        run_msg(0);

        // Backpressure on "abc", then "ab" back-to-back.
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(10);
        msg = '{8'h61, 8'h62};
        run_msg(0);

        // Reset after 20 bytes of a message: nothing emitted, length restarts.
        for (int i = 0; i < 20; i++) send_beat(8'hA5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 512'(in_ready), 512'd0);
        chk("midrst_valid", 512'(block_valid), 512'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (block_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_block", 512'(seen), 512'd0);
        msg = '{8'h61, 8'h62};
        run_msg(0);

        chk("sb_drained", 512'(sb.size()), 512'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
